// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with an internal transmit FIFO and a valid/ready push port.
// Latency: a word pushed at cycle t into an empty FIFO with the line idle starts its START bit at t+2.
//   Frames stream back-to-back while the FIFO holds data.
// Backpressure: Ready_o drops while the FIFO is full and depends only on registered state.
// Ports: Clk/Rst_n (synchronous, active-low); Data_i/Valid_i/Ready_o push side; Parity_odd parity sense;
//   TXD serial line (idle high); Busy, EOT (last cycle of each frame), Fifo_level status.
// Optional feature: define UART_TX_PARITY_EN to append a parity bit to every frame.
module uart_tx_cfg #(
  parameter int FREQ_CLK   = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic [DATA_BITS-1:0]          Data_i,
  input  logic                          Valid_i,
  output logic                          Ready_o,
  input  logic                          Parity_odd,
  output logic                          TXD,
  output logic                          Busy,
  output logic                          EOT,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_level
);
  localparam int DIV = FREQ_CLK / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int BW  = 4;  // wide enough for a data index up to 8 and a stop index up to 1

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_cfg: FREQ_CLK/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, at least 2");
  end

  // ---------------- transmit FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic                 push, pop, fifo_empty;
  logic [DATA_BITS-1:0] head;

  assign Ready_o    = (level != LW'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign push       = Valid_i && Ready_o;
  assign head       = mem[rd_ptr];
  assign Fifo_level = level;

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= Data_i;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------- frame FSM ----------------
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_q;  // parity bit value, fixed when the word is popped
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic unused_parity_odd;
  assign unused_parity_odd = Parity_odd;
`endif

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 txd_q;
  logic                 bit_end, last_stop;

  assign bit_end   = (cnt == CW'(DIV - 1));
  assign last_stop = (bit_idx == BW'(STOP_BITS - 1));
  assign EOT       = (state == STOP) && bit_end && last_stop;
  // Pop from IDLE, or in the final stop cycle so the next START follows with no gap.
  assign pop       = !fifo_empty && ((state == IDLE) || EOT);
  assign Busy      = (state != IDLE);
  assign TXD       = txd_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      // Every state change happens on bit_end (or out of IDLE), so this also clears on entry.
      cnt <= (bit_end || state == IDLE) ? '0 : cnt + CW'(1);
      // txd_q is loaded with the level of the state being entered, so the line is registered.
      case (state)
        IDLE: begin
          if (pop) begin
            shift   <= head;
            bit_idx <= '0;
            txd_q   <= 1'b0;
            state   <= START;
`ifdef UART_TX_PARITY_EN
            par_q   <= (^head) ^ Parity_odd;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            txd_q <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_idx == BW'(DATA_BITS - 1)) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              txd_q   <= par_q;
`else
              state   <= STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + BW'(1);
              txd_q   <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            txd_q <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (!last_stop) begin
              bit_idx <= bit_idx + BW'(1);
            end else if (pop) begin
              shift   <= head;
              bit_idx <= '0;
              txd_q   <= 1'b0;
              state   <= START;
`ifdef UART_TX_PARITY_EN
              par_q   <= (^head) ^ Parity_odd;
`endif
            end else begin
              bit_idx <= '0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          txd_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
